// File: rtl/flash_pkg.sv
// Shared definitions for the parallel NOR flash read path: FSM encoding,
// device size and the default access timing.
package flash_pkg;

  typedef enum logic [2:0] {
    FL_RST = 3'd0,
    FL_REC = 3'd1,
    IDLE   = 3'd2,
    RD_HI  = 3'd3,
    RD_LO  = 3'd4,
    DONE   = 3'd5
  } fl_state_e;

  localparam int FL_BYTES       = 8388608;
  localparam int FL_WAIT_CYCLES = 5;
  localparam int FL_RST_CYCLES  = 30;
  localparam int FL_REC_CYCLES  = 15;

endpackage

// File: rtl/flash_reader.sv
// Serves 16-bit big-endian word reads from the 8-bit NOR flash over a toggle
// req/ack handshake, after running the flash reset/recovery sequence.
module flash_reader
  import flash_pkg::*;
#(
  parameter int WAIT_CYCLES = FL_WAIT_CYCLES,
  parameter int RST_CYCLES  = FL_RST_CYCLES,
  parameter int REC_CYCLES  = FL_REC_CYCLES
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic [23:1] iaddr,
  input  logic        ireq,
  output logic        oack,
  output logic [15:0] odata,
  output logic        oready,
  output logic [22:0] ofl_addr,
  input  logic [7:0]  ifl_dq,
  output logic        ofl_ce_n,
  output logic        ofl_oe_n,
  output logic        ofl_we_n,
  output logic        ofl_rst_n,
  output logic        ofl_wp_n
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] RST_LOAD  = 8'(RST_CYCLES - 1);
  localparam logic [7:0] REC_LOAD  = 8'(REC_CYCLES - 1);

  fl_state_e   state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [7:0]  seqCnt_q, seqCnt_d;
  logic        reqLvl_q, reqLvl_d;
  logic [21:0] word_q, word_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic        ready_q, ready_d;
  logic [22:0] addr_q, addr_d;
  logic        ceN_q, ceN_d;
  logic        oeN_q, oeN_d;
  logic        rstN_q, rstN_d;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q   <= FL_RST;
      waitCnt_q <= WAIT_LOAD;
      seqCnt_q  <= RST_LOAD;
      reqLvl_q  <= 1'b0;
      word_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      addr_q    <= '0;
      ceN_q     <= 1'b1;
      oeN_q     <= 1'b1;
      rstN_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      seqCnt_q  <= seqCnt_d;
      reqLvl_q  <= reqLvl_d;
      word_q    <= word_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      ceN_q     <= ceN_d;
      oeN_q     <= oeN_d;
      rstN_q    <= rstN_d;
    end
  end

  // Counters load "cycles - 1" on state entry and the zero count is the final
  // cycle, so each byte is sampled exactly WAIT_CYCLES edges after its address.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    seqCnt_d  = seqCnt_q;
    reqLvl_d  = reqLvl_q;
    word_d    = word_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    data_d    = data_q;
    ack_d     = ack_q;
    ready_d   = ready_q;
    addr_d    = addr_q;
    ceN_d     = ceN_q;
    oeN_d     = oeN_q;
    rstN_d    = rstN_q;

    case (state_q)
      FL_RST: begin
        if (seqCnt_q == '0) begin
          rstN_d   = 1'b1;
          seqCnt_d = REC_LOAD;
          state_d  = FL_REC;
        end else begin
          seqCnt_d = seqCnt_q - 8'd1;
        end
      end
      FL_REC: begin
        if (seqCnt_q == '0) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          seqCnt_d = seqCnt_q - 8'd1;
        end
      end
      IDLE: begin
        if (ireq != ack_q) begin
          reqLvl_d  = ireq;
          word_d    = iaddr[22:1];
          addr_d    = {iaddr[22:1], 1'b0};
          ceN_d     = 1'b0;
          oeN_d     = 1'b0;
          waitCnt_d = WAIT_LOAD;
          state_d   = RD_HI;
        end
      end
      RD_HI: begin
        if (waitCnt_q == '0) begin
          hi_d      = ifl_dq;
          addr_d    = {word_q, 1'b1};
          waitCnt_d = WAIT_LOAD;
          state_d   = RD_LO;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      RD_LO: begin
        if (waitCnt_q == '0) begin
          lo_d    = ifl_dq;
          state_d = DONE;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      DONE: begin
        data_d  = {hi_q, lo_q};
        ack_d   = reqLvl_q;
        ceN_d   = 1'b1;
        oeN_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = FL_RST;
    endcase
  end

  assign oack      = ack_q;
  assign odata     = data_q;
  assign oready    = ready_q;
  assign ofl_addr  = addr_q;
  assign ofl_ce_n  = ceN_q;
  assign ofl_oe_n  = oeN_q;
  assign ofl_rst_n = rstN_q;
  assign ofl_we_n  = 1'b1;
  assign ofl_wp_n  = 1'b1;

endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader: behavioural NOR flash model, a table of
// single reads, and hand-written reset, early-request, streaming and abort cases.
`timescale 1ns/1ps
module tb_flash_reader;

  localparam int WAIT = 5;

  logic        iclk = 1'b0;
  logic        ireset_n = 1'b0;
  logic [23:1] iaddr = '0;
  logic        ireq = 1'b0;
  logic        oack;
  logic [15:0] odata;
  logic        oready;
  logic [22:0] ofl_addr;
  logic [7:0]  ifl_dq = 8'h00;
  logic        ofl_ce_n, ofl_oe_n, ofl_we_n, ofl_rst_n, ofl_wp_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  flash_reader dut (
    .iclk(iclk), .ireset_n(ireset_n), .iaddr(iaddr), .ireq(ireq),
    .oack(oack), .odata(odata), .oready(oready), .ofl_addr(ofl_addr),
    .ifl_dq(ifl_dq), .ofl_ce_n(ofl_ce_n), .ofl_oe_n(ofl_oe_n),
    .ofl_we_n(ofl_we_n), .ofl_rst_n(ofl_rst_n), .ofl_wp_n(ofl_wp_n)
  );

  always #10 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  // Flash model: byte storage, unwritten bytes read as erased (0xFF).
  logic [7:0] mem [logic [22:0]];

  function automatic logic [7:0] memRead(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'hFF;
  endfunction

  always @(negedge iclk)
    ifl_dq = (!ofl_ce_n && !ofl_oe_n) ? memRead(ofl_addr) : 8'h00;

  typedef struct {
    logic [23:1] addr;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] expData;
    logic [22:0] expHiAddr;
    logic [22:0] expLoAddr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:1] addr);
    iaddr = addr;
    ireq  = ~ireq;
  endtask

  // Issues one request and returns the ack latency in edges (-1 on timeout)
  // plus the flash address seen during the high and low byte phases.
  task automatic runRead(input logic [23:1] addr, output int lat,
                         output logic [22:0] a0, output logic [22:0] a1);
    applyStimulus(addr);
    lat = -1;
    a0  = 'x;
    a1  = 'x;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) a0 = ofl_addr;
      if (n == WAIT + 1) a1 = ofl_addr;
      if (oack == ireq) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, firstRstHigh, firstReady, ackCycle, ackToggles, lastAck, n;
    logic [22:0] a0, a1;
    logic prevAck, newLvl;

    vecs[0] = '{23'h000000, 8'h12, 8'h34, 16'h1234, 23'h000000, 23'h000001};
    vecs[1] = '{23'h000001, 8'hA5, 8'h5A, 16'hA55A, 23'h000002, 23'h000003};
    vecs[2] = '{23'h400005, 8'h0F, 8'hF0, 16'h0FF0, 23'h00000A, 23'h00000B};
    vecs[3] = '{23'h3FFFFF, 8'hAB, 8'hCD, 16'hABCD, 23'h7FFFFE, 23'h7FFFFF};
    vecs[4] = '{23'h155555, 8'h00, 8'hFF, 16'h00FF, 23'h2AAAAA, 23'h2AAAAB};
    vecs[5] = '{23'h2AAAAA, 8'hC3, 8'h3C, 16'hC33C, 23'h555554, 23'h555555};

    mem[23'h000000] = 8'h12;
    mem[23'h000001] = 8'h34;

    repeat (3) @(posedge iclk);
    #1;
    checkOutput("reset_outputs",
      {oack, odata, oready, ofl_addr, ofl_ce_n, ofl_oe_n, ofl_we_n, ofl_rst_n, ofl_wp_n},
      {1'b0, 16'h0000, 1'b0, 23'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});

    // Reset sequence with a request toggled while the flash is still in reset.
    @(negedge iclk);
    ireset_n = 1'b1;
    firstRstHigh = -1;
    firstReady   = -1;
    ackCycle     = -1;
    ackToggles   = 0;
    prevAck      = oack;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ofl_rst_n && firstRstHigh < 0) firstRstHigh = k;
      if (oready && firstReady < 0) firstReady = k;
      if (oack != prevAck) begin
        ackToggles++;
        if (ackCycle < 0) ackCycle = k;
      end
      prevAck = oack;
      if (k == 5) applyStimulus(23'h000000);
    end
    checkOutput("rst_release_cycle", 64'(firstRstHigh), 64'd30);
    checkOutput("ready_cycle", 64'(firstReady), 64'd45);
    checkOutput("early_ack_cycle", 64'(ackCycle), 64'd57);
    checkOutput("early_ack_toggles", 64'(ackToggles), 64'd1);
    checkOutput("early_data", 64'(odata), 64'h1234);

    // Table of single reads.
    foreach (vecs[i]) begin
      mem[vecs[i].expHiAddr] = vecs[i].hi;
      mem[vecs[i].expLoAddr] = vecs[i].lo;
    end
    foreach (vecs[i]) begin
      repeat (2) tick();
      runRead(vecs[i].addr, lat, a0, a1);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd12);
      checkOutput($sformatf("vec%0d_data", i), 64'(odata), 64'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_hi_addr", i), 64'(a0), 64'(vecs[i].expHiAddr));
      checkOutput($sformatf("vec%0d_lo_addr", i), 64'(a1), 64'(vecs[i].expLoAddr));
      checkOutput($sformatf("vec%0d_ce_oe", i), {62'd0, ofl_ce_n, ofl_oe_n}, 64'd3);
    end

    // A toggle back during a read is not a new request; the mismatch that
    // remains afterwards starts a second read after a single idle cycle.
    mem[23'h000006] = 8'h11;
    mem[23'h000007] = 8'h22;
    tick();
    applyStimulus(23'h000003);
    newLvl = ireq;
    n = 0;
    repeat (3) begin
      tick();
      n++;
    end
    ireq = ~ireq;
    while (oack != newLvl && n < 40) begin
      tick();
      n++;
    end
    checkOutput("retoggle_first_latency", 64'(n), 64'd12);
    checkOutput("retoggle_first_data", 64'(odata), 64'h1122);
    n = 0;
    while (oack != ireq && n < 40) begin
      tick();
      n++;
    end
    checkOutput("retoggle_second_gap", 64'(n), 64'd12);
    checkOutput("retoggle_second_data", 64'(odata), 64'h1122);

    // Streaming with a registered requester that re-toggles one edge after ack.
    for (int k = 0; k < 512; k++) mem[23'(k)] = 8'($urandom);
    tick();
    lastAck = 0;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(23'(k));
      n = 0;
      while (oack != ireq && n < 40) begin
        tick();
        n++;
      end
      checkOutput($sformatf("stream%0d_ack", k), 64'(oack), 64'(ireq));
      checkOutput($sformatf("stream%0d_data", k), 64'(odata),
                  64'({mem[23'(2*k)], mem[23'(2*k+1)]}));
      if (k > 0) checkOutput($sformatf("stream%0d_spacing", k), 64'(cyc - lastAck), 64'd13);
      lastAck = cyc;
      tick();
    end

    // Abort a read in its low-byte phase with oack high and odata nonzero.
    mem[23'h000200] = 8'h5A;
    mem[23'h000201] = 8'hA5;
    mem[23'h000020] = 8'h9C;
    mem[23'h000021] = 8'h3E;
    runRead(23'h000100, lat, a0, a1);
    if (!oack) begin
      tick();
      runRead(23'h000100, lat, a0, a1);
    end
    checkOutput("pre_abort_state", {47'd0, oack, odata}, {47'd0, 1'b1, 16'h5AA5});
    tick();
    applyStimulus(23'h000010);
    repeat (8) tick();
    #2;
    ireset_n = 1'b0;
    #1;
    checkOutput("abort_async_outputs",
      {oack, odata, oready, ofl_addr, ofl_ce_n, ofl_oe_n, ofl_rst_n},
      {1'b0, 16'h0000, 1'b0, 23'h0, 1'b1, 1'b1, 1'b0});
    ireq = 1'b0;
    repeat (2) tick();
    @(negedge iclk);
    ireset_n = 1'b1;
    firstRstHigh = -1;
    firstReady   = -1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ofl_rst_n && firstRstHigh < 0) firstRstHigh = k;
      if (oready && firstReady < 0) begin
        firstReady = k;
        break;
      end
    end
    checkOutput("rerun_rst_release", 64'(firstRstHigh), 64'd30);
    checkOutput("rerun_ready", 64'(firstReady), 64'd45);
    runRead(23'h000010, lat, a0, a1);
    checkOutput("after_abort_latency", 64'(lat), 64'd12);
    checkOutput("after_abort_data", 64'(odata), 64'h9C3E);
    checkOutput("after_abort_ack", 64'(oack), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
